// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                                 |
// | Brief    : IF fetch and EU load/store request/response bundle.            |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
interface mem_arbiter_if;
   logic        if_req;
   logic [19:0] if_addr;
   logic        if_gnt;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;

   logic        eu_req;
   logic        eu_wr;
   logic        eu_word;
   logic [19:0] eu_addr;
   logic [15:0] eu_wdata;
   logic        eu_gnt;
   logic        eu_rsp_valid;
   logic [15:0] eu_rdata;

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rsp_valid, if_rsp_data,
      output eu_req, eu_wr, eu_word, eu_addr, eu_wdata,
      input  eu_gnt, eu_rsp_valid, eu_rdata
   );

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rsp_valid, if_rsp_data,
      input  eu_req, eu_wr, eu_word, eu_addr, eu_wdata,
      output eu_gnt, eu_rsp_valid, eu_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                    |
// | Brief    : Shares a 1R/1W byte RAM between instruction fetch and the EU.  |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         ram_rd_en,
   output logic         ram_rd_we,
   output logic         ram_rd_de,
   output logic [19:0]  ram_rd_addr,
   input  logic [31:0]  ram_rd_data,
   output logic         ram_wr_en,
   output logic         ram_wr_we,
   output logic         ram_wr_de,
   output logic [19:0]  ram_wr_addr,
   output logic [31:0]  ram_wr_data
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SPLIT_RD = 2'd1;
   localparam logic [1:0] ST_SPLIT_WR = 2'd2;
   localparam logic [3:0] C_LIMIT     = 4'(STARVE_LIMIT);

   logic [1:0]  state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [19:0] addr_q, addr_d;
   logic [7:0]  whi_q, whi_d;
   logic [7:0]  byte0_q, byte0_d;
   logic        if_rsp_valid_q, if_rsp_valid_d;
   logic [31:0] if_rsp_data_q, if_rsp_data_d;
   logic        eu_rsp_valid_q, eu_rsp_valid_d;
   logic [15:0] eu_rdata_q, eu_rdata_d;

   logic        eu_aligned;
   logic        if_wins;
   logic        fetch;
   logic        if_lost;
   logic        eu_gnt_c;
   logic        rd_en_c, rd_we_c, rd_de_c;
   logic [19:0] rd_addr_c;
   logic        wr_en_c, wr_we_c;
   logic [19:0] wr_addr_c;
   logic [31:0] wr_data_c;
   logic        eu_rd_done, eu_wr_done, split_rd_start, split_rd_done;
   logic        unused_if_addr_lo;

   assign eu_aligned        = !bus.eu_word || !bus.eu_addr[0];
   assign if_wins           = (starve_q == C_LIMIT);
   assign unused_if_addr_lo = ^bus.if_addr[1:0];

   // Control path: never looks at ram_rd_data, so RAM read data cannot loop back into addresses.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      whi_d          = whi_q;
      fetch          = 1'b0;
      if_lost        = 1'b0;
      eu_gnt_c       = 1'b0;
      rd_en_c        = 1'b0;
      rd_we_c        = 1'b0;
      rd_de_c        = 1'b0;
      rd_addr_c      = '0;
      wr_en_c        = 1'b0;
      wr_we_c        = 1'b0;
      wr_addr_c      = '0;
      wr_data_c      = '0;
      eu_rd_done     = 1'b0;
      eu_wr_done     = 1'b0;
      split_rd_start = 1'b0;
      split_rd_done  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.eu_req && bus.eu_wr) begin
               eu_gnt_c  = 1'b1;
               fetch     = bus.if_req;
               wr_en_c   = 1'b1;
               wr_addr_c = bus.eu_addr;
               wr_data_c = {24'h0, bus.eu_wdata[7:0]};
               if (eu_aligned) begin
                  wr_we_c    = bus.eu_word;
                  eu_wr_done = 1'b1;
                  if (bus.eu_word) begin
                     wr_data_c = {16'h0, bus.eu_wdata};
                  end
               end else begin
                  addr_d  = bus.eu_addr + 20'd1;
                  whi_d   = bus.eu_wdata[15:8];
                  state_d = ST_SPLIT_WR;
               end
            end else if (bus.eu_req && !(bus.if_req && if_wins)) begin
               eu_gnt_c  = 1'b1;
               if_lost   = bus.if_req;
               rd_en_c   = 1'b1;
               rd_addr_c = bus.eu_addr;
               if (eu_aligned) begin
                  rd_we_c    = bus.eu_word;
                  eu_rd_done = 1'b1;
               end else begin
                  split_rd_start = 1'b1;
                  addr_d         = bus.eu_addr + 20'd1;
                  state_d        = ST_SPLIT_RD;
               end
            end else begin
               fetch = bus.if_req;
            end
         end
         ST_SPLIT_RD: begin
            rd_en_c       = 1'b1;
            rd_addr_c     = addr_q;
            if_lost       = bus.if_req;
            split_rd_done = 1'b1;
            state_d       = ST_IDLE;
         end
         ST_SPLIT_WR: begin
            wr_en_c    = 1'b1;
            wr_addr_c  = addr_q;
            wr_data_c  = {24'h0, whi_q};
            eu_wr_done = 1'b1;
            fetch      = bus.if_req;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fetch) begin
         rd_en_c   = 1'b1;
         rd_de_c   = 1'b1;
         rd_addr_c = {bus.if_addr[19:2], 2'b00};
      end

      if (fetch) begin
         starve_d = '0;
      end else if (if_lost && (starve_q != C_LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   always_comb begin
      if_rsp_valid_d = fetch;
      if_rsp_data_d  = fetch ? ram_rd_data : if_rsp_data_q;
      eu_rsp_valid_d = eu_rd_done | eu_wr_done | split_rd_done;
      byte0_d        = split_rd_start ? ram_rd_data[7:0] : byte0_q;
      if (eu_rd_done) begin
         eu_rdata_d = bus.eu_word ? ram_rd_data[15:0] : {8'h0, ram_rd_data[7:0]};
      end else if (split_rd_done) begin
         eu_rdata_d = {ram_rd_data[7:0], byte0_q};
      end else if (eu_wr_done) begin
         eu_rdata_d = '0;
      end else begin
         eu_rdata_d = eu_rdata_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         starve_q       <= '0;
         addr_q         <= '0;
         whi_q          <= '0;
         byte0_q        <= '0;
         if_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         eu_rsp_valid_q <= 1'b0;
         eu_rdata_q     <= '0;
      end else begin
         state_q        <= state_d;
         starve_q       <= starve_d;
         addr_q         <= addr_d;
         whi_q          <= whi_d;
         byte0_q        <= byte0_d;
         if_rsp_valid_q <= if_rsp_valid_d;
         if_rsp_data_q  <= if_rsp_data_d;
         eu_rsp_valid_q <= eu_rsp_valid_d;
         eu_rdata_q     <= eu_rdata_d;
      end
   end

   // Combinational outputs are forced quiet for as long as reset is held.
   assign bus.if_gnt       = fetch    & ~rst;
   assign bus.eu_gnt       = eu_gnt_c & ~rst;
   assign ram_rd_en        = rd_en_c  & ~rst;
   assign ram_rd_we        = rd_we_c  & ~rst;
   assign ram_rd_de        = rd_de_c  & ~rst;
   assign ram_rd_addr      = rst ? 20'h0 : rd_addr_c;
   assign ram_wr_en        = wr_en_c  & ~rst;
   assign ram_wr_we        = wr_we_c  & ~rst;
   assign ram_wr_de        = 1'b0;
   assign ram_wr_addr      = rst ? 20'h0 : wr_addr_c;
   assign ram_wr_data      = rst ? 32'h0 : wr_data_c;

   assign bus.if_rsp_valid = if_rsp_valid_q;
   assign bus.if_rsp_data  = if_rsp_data_q;
   assign bus.eu_rsp_valid = eu_rsp_valid_q;
   assign bus.eu_rdata     = eu_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                 |
// | Brief    : Directed self-checking bench for mem_arbiter with a RAM model. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_mem_arbiter;
   logic        clk;
   logic        rst;
   logic        ram_rd_en, ram_rd_we, ram_rd_de;
   logic [19:0] ram_rd_addr;
   logic [31:0] ram_rd_data;
   logic        ram_wr_en, ram_wr_we, ram_wr_de;
   logic [19:0] ram_wr_addr;
   logic [31:0] ram_wr_data;

   logic [7:0]   mem [0:1048575];
   int           checks;
   int           failures;
   logic [127:0] act_v, exp_v;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_we   (ram_rd_we),
      .ram_rd_de   (ram_rd_de),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_we   (ram_wr_we),
      .ram_wr_de   (ram_wr_de),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM byte with same-cycle write forwarding.
   function automatic logic [7:0] rb(input logic [19:0] a);
      logic [7:0] v;
      v = mem[a];
      if (ram_wr_en) begin
         if (ram_wr_we) begin
            if (a == {ram_wr_addr[19:1], 1'b0}) v = ram_wr_data[7:0];
            if (a == {ram_wr_addr[19:1], 1'b1}) v = ram_wr_data[15:8];
         end else if (a == ram_wr_addr) begin
            v = ram_wr_data[7:0];
         end
      end
      return v;
   endfunction

   always_comb begin
      ram_rd_data = '0;
      if (ram_rd_en) begin
         if (ram_rd_de)
            ram_rd_data = {rb({ram_rd_addr[19:2], 2'b11}), rb({ram_rd_addr[19:2], 2'b10}),
                           rb({ram_rd_addr[19:2], 2'b01}), rb({ram_rd_addr[19:2], 2'b00})};
         else if (ram_rd_we)
            ram_rd_data = {16'h0, rb({ram_rd_addr[19:1], 1'b1}), rb({ram_rd_addr[19:1], 1'b0})};
         else
            ram_rd_data = {24'h0, rb(ram_rd_addr)};
      end
   end

   always @(negedge clk) begin
      if (ram_wr_en) begin
         if (ram_wr_we) begin
            mem[{ram_wr_addr[19:1], 1'b0}] = ram_wr_data[7:0];
            mem[{ram_wr_addr[19:1], 1'b1}] = ram_wr_data[15:8];
         end else begin
            mem[ram_wr_addr] = ram_wr_data[7:0];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.eu_req   = 1'b0;
      bus.eu_wr    = 1'b0;
      bus.eu_word  = 1'b0;
      bus.eu_addr  = '0;
      bus.eu_wdata = '0;
   endtask

   task automatic test_reset();
      bus.if_req  = 1'b1;
      bus.if_addr = 20'h00100;
      tick();
      act_v = 128'({bus.if_rsp_valid, bus.if_rsp_data});
      exp_v = 128'({1'b1, 32'h44332211});
      if (act_v !== exp_v) begin failures++; $display("FAIL pre_reset_rsp: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      #2 rst = 1'b1;
      #1;
      act_v = 128'({bus.if_gnt, bus.eu_gnt, bus.if_rsp_valid, bus.eu_rsp_valid, bus.eu_rdata, bus.if_rsp_data,
                    ram_rd_en, ram_rd_we, ram_rd_de, ram_rd_addr, ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data});
      exp_v = '0;
      if (act_v !== exp_v) begin failures++; $display("FAIL async_reset_outputs: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      #2;
      rst         = 1'b0;
      bus.if_addr = 20'h00103;
      #1;
      act_v = 128'({bus.if_gnt, ram_rd_en, ram_rd_de, ram_rd_we, ram_rd_addr});
      exp_v = 128'({1'b1, 1'b1, 1'b1, 1'b0, 20'h00100});
      if (act_v !== exp_v) begin failures++; $display("FAIL fetch_drive: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.if_req = 1'b0;
      mid();
      act_v = 128'({bus.if_rsp_valid, bus.if_rsp_data});
      exp_v = 128'({1'b1, 32'h44332211});
      if (act_v !== exp_v) begin failures++; $display("FAIL fetch_rsp: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      mid();
      if (bus.if_rsp_valid !== 1'b0) begin failures++; $display("FAIL fetch_rsp_pulse: actual=%0h expected=0", bus.if_rsp_valid); end
      checks++;
      tick();
   endtask

   task automatic test_unaligned_rw(input logic [19:0] addr, input logic [15:0] data);
      logic [19:0] a1;
      a1 = addr + 20'd1;
      bus.eu_req = 1'b1; bus.eu_wr = 1'b1; bus.eu_word = 1'b1;
      bus.eu_addr = addr; bus.eu_wdata = data;
      mid();
      act_v = 128'({bus.eu_gnt, ram_wr_en, ram_wr_we, ram_wr_de, ram_rd_en, ram_wr_addr, ram_wr_data});
      exp_v = 128'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, addr, 24'h0, data[7:0]});
      if (act_v !== exp_v) begin failures++; $display("FAIL split_wr_first: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_req = 1'b0;
      mid();
      act_v = 128'({bus.eu_gnt, ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data, bus.eu_rsp_valid});
      exp_v = 128'({1'b0, 1'b1, 1'b0, a1, 24'h0, data[15:8], 1'b0});
      if (act_v !== exp_v) begin failures++; $display("FAIL split_wr_second: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      mid();
      act_v = 128'({bus.eu_rsp_valid, bus.eu_rdata, mem[addr], mem[a1]});
      exp_v = 128'({1'b1, 16'h0, data[7:0], data[15:8]});
      if (act_v !== exp_v) begin failures++; $display("FAIL split_wr_rsp_mem: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_req = 1'b1; bus.eu_wr = 1'b0; bus.eu_word = 1'b1; bus.eu_addr = addr;
      mid();
      act_v = 128'({bus.eu_gnt, ram_rd_en, ram_rd_we, ram_rd_de, ram_rd_addr});
      exp_v = 128'({1'b1, 1'b1, 1'b0, 1'b0, addr});
      if (act_v !== exp_v) begin failures++; $display("FAIL split_rd_first: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_req = 1'b0;
      mid();
      act_v = 128'({bus.eu_gnt, ram_rd_en, ram_rd_we, ram_rd_de, ram_rd_addr, bus.eu_rsp_valid});
      exp_v = 128'({1'b0, 1'b1, 1'b0, 1'b0, a1, 1'b0});
      if (act_v !== exp_v) begin failures++; $display("FAIL split_rd_second: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      mid();
      act_v = 128'({bus.eu_rsp_valid, bus.eu_rdata});
      exp_v = 128'({1'b1, data});
      if (act_v !== exp_v) begin failures++; $display("FAIL split_rd_rsp: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
   endtask

   task automatic test_starvation();
      logic e_win, p_eu, p_if;
      bus.eu_req = 1'b1; bus.eu_wr = 1'b0; bus.eu_word = 1'b1; bus.eu_addr = 20'h00400;
      bus.if_req = 1'b1; bus.if_addr = 20'h00500;
      for (int i = 0; i < 10; i++) begin
         e_win = ((i % 5) != 4);
         p_eu  = (i == 0) ? 1'b0 : (((i - 1) % 5) != 4);
         p_if  = (i != 0) && !p_eu;
         mid();
         act_v = 128'({bus.if_gnt, bus.eu_gnt, bus.eu_rsp_valid, bus.if_rsp_valid,
                       (p_eu ? bus.eu_rdata : 16'h0)});
         exp_v = 128'({~e_win, e_win, p_eu, p_if, (p_eu ? 16'hBC9A : 16'h0)});
         if (act_v !== exp_v) begin failures++; $display("FAIL starve_cycle%0d: actual=%0h expected=%0h", i, act_v, exp_v); end
         checks++;
         tick();
      end
      bus.eu_req = 1'b0;
      bus.if_req = 1'b0;
      tick();
   endtask

   task automatic test_concurrent();
      bus.eu_req = 1'b1; bus.eu_wr = 1'b1; bus.eu_word = 1'b1;
      bus.eu_addr = 20'h00300; bus.eu_wdata = 16'hA55A;
      bus.if_req = 1'b1; bus.if_addr = 20'h00300;
      mid();
      act_v = 128'({bus.if_gnt, bus.eu_gnt, ram_rd_en, ram_rd_de, ram_rd_addr,
                    ram_wr_en, ram_wr_we, ram_wr_de, ram_wr_addr, ram_wr_data});
      exp_v = 128'({1'b1, 1'b1, 1'b1, 1'b1, 20'h00300, 1'b1, 1'b1, 1'b0, 20'h00300, 32'h0000A55A});
      if (act_v !== exp_v) begin failures++; $display("FAIL concurrent_drive: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_req = 1'b0;
      bus.if_req = 1'b0;
      mid();
      act_v = 128'({bus.if_rsp_valid, bus.if_rsp_data, bus.eu_rsp_valid, bus.eu_rdata});
      exp_v = 128'({1'b1, 32'h6677A55A, 1'b1, 16'h0});
      if (act_v !== exp_v) begin failures++; $display("FAIL concurrent_rsp: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
   endtask

   task automatic test_split_rd_blocks_if();
      bus.eu_req = 1'b1; bus.eu_wr = 1'b0; bus.eu_word = 1'b1; bus.eu_addr = 20'h00601;
      bus.if_req = 1'b1; bus.if_addr = 20'h00700;
      mid();
      act_v = 128'({bus.if_gnt, bus.eu_gnt, ram_rd_de, ram_rd_addr});
      exp_v = 128'({1'b0, 1'b1, 1'b0, 20'h00601});
      if (act_v !== exp_v) begin failures++; $display("FAIL blk_accept: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_req = 1'b0;
      mid();
      act_v = 128'({bus.if_gnt, bus.eu_gnt, ram_rd_addr, bus.eu_rsp_valid});
      exp_v = 128'({1'b0, 1'b0, 20'h00602, 1'b0});
      if (act_v !== exp_v) begin failures++; $display("FAIL blk_split_cycle: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      mid();
      act_v = 128'({bus.if_gnt, ram_rd_de, ram_rd_addr, bus.eu_rsp_valid, bus.eu_rdata});
      exp_v = 128'({1'b1, 1'b1, 20'h00700, 1'b1, 16'hC35A});
      if (act_v !== exp_v) begin failures++; $display("FAIL blk_if_grant: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.if_req = 1'b0;
      mid();
      act_v = 128'({bus.if_rsp_valid, bus.if_rsp_data});
      exp_v = 128'({1'b1, 32'h04030201});
      if (act_v !== exp_v) begin failures++; $display("FAIL blk_if_rsp: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
   endtask

   task automatic test_back_to_back();
      bus.eu_req = 1'b1; bus.eu_wr = 1'b0; bus.eu_word = 1'b0; bus.eu_addr = 20'h00601;
      mid();
      act_v = 128'({bus.eu_gnt, ram_rd_en, ram_rd_we, ram_rd_de, ram_rd_addr});
      exp_v = 128'({1'b1, 1'b1, 1'b0, 1'b0, 20'h00601});
      if (act_v !== exp_v) begin failures++; $display("FAIL b2b_first: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_addr = 20'h00602;
      mid();
      act_v = 128'({bus.eu_gnt, bus.eu_rsp_valid, bus.eu_rdata});
      exp_v = 128'({1'b1, 1'b1, 16'h005A});
      if (act_v !== exp_v) begin failures++; $display("FAIL b2b_second: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      bus.eu_req = 1'b0;
      mid();
      act_v = 128'({bus.eu_rsp_valid, bus.eu_rdata});
      exp_v = 128'({1'b1, 16'h00C3});
      if (act_v !== exp_v) begin failures++; $display("FAIL b2b_rsp2: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      mid();
      if (bus.eu_rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: actual=%0h expected=0", bus.eu_rsp_valid); end
      checks++;
      tick();
   endtask

   task automatic test_reset_mid_split();
      bus.eu_req = 1'b1; bus.eu_wr = 1'b1; bus.eu_word = 1'b1;
      bus.eu_addr = 20'h00801; bus.eu_wdata = 16'hDDCC;
      mid();
      if (bus.eu_gnt !== 1'b1) begin failures++; $display("FAIL rsplit_gnt: actual=%0h expected=1", bus.eu_gnt); end
      checks++;
      tick();
      bus.eu_req = 1'b0;
      #1 rst = 1'b1;
      #1;
      act_v = 128'({ram_wr_en, ram_wr_addr, ram_wr_data});
      exp_v = '0;
      if (act_v !== exp_v) begin failures++; $display("FAIL rsplit_quiet: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      #1 rst = 1'b0;
      mid();
      act_v = 128'({ram_wr_en, bus.eu_rsp_valid});
      exp_v = '0;
      if (act_v !== exp_v) begin failures++; $display("FAIL rsplit_abandon: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
      mid();
      act_v = 128'({bus.eu_rsp_valid, mem[20'h00801], mem[20'h00802]});
      exp_v = 128'({1'b0, 8'hCC, 8'h55});
      if (act_v !== exp_v) begin failures++; $display("FAIL rsplit_mem: actual=%0h expected=%0h", act_v, exp_v); end
      checks++;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      mem[20'h00100] = 8'h11; mem[20'h00101] = 8'h22; mem[20'h00102] = 8'h33; mem[20'h00103] = 8'h44;
      mem[20'h00201] = 8'h00; mem[20'h00202] = 8'h00;
      mem[20'hFFFFF] = 8'h00; mem[20'h00000] = 8'h00;
      mem[20'h00300] = 8'h00; mem[20'h00301] = 8'h00; mem[20'h00302] = 8'h77; mem[20'h00303] = 8'h66;
      mem[20'h00400] = 8'h9A; mem[20'h00401] = 8'hBC;
      mem[20'h00601] = 8'h5A; mem[20'h00602] = 8'hC3;
      mem[20'h00700] = 8'h01; mem[20'h00701] = 8'h02; mem[20'h00702] = 8'h03; mem[20'h00703] = 8'h04;
      mem[20'h00801] = 8'h00; mem[20'h00802] = 8'h55;
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      test_reset();
      test_unaligned_rw(20'h00201, 16'hBEEF);
      test_unaligned_rw(20'hFFFFF, 16'h1234);
      test_starvation();
      test_concurrent();
      test_split_rd_blocks_if();
      test_back_to_back();
      test_reset_mid_split();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
